opb_slave_bank_ctrl: RTL and testbench



---
 rtl/opb_slave_bank_ctrl.sv | 150 +++++++++++++++
 tb/tb_opb_slave_bank_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/opb_slave_bank_ctrl.sv
// Shares one OPB slave attachment between C_NUM_SLAVES register slaves.
// Decodes the address and selects one slave. Ack and data go back registered. A silent slave ends in errAck.
module opb_slave_bank_ctrl #(
  parameter int unsigned C_NUM_SLAVES = 4,
  parameter logic [31:0] C_BASEADDR   = 32'h01188000,
  parameter logic [31:0] C_SLAVE_SPAN = 32'h00000100,
  parameter int unsigned C_TIMEOUT    = 16
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:31]               OPB_ABus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:31]               Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [C_NUM_SLAVES-1:0]   S_select,
  input  logic [32*C_NUM_SLAVES-1:0] S_DBus,
  input  logic [C_NUM_SLAVES-1:0]   S_xferAck,
  input  logic [C_NUM_SLAVES-1:0]   S_toutSup,
  output logic [1:0]                o_dbg_state
);

  localparam int unsigned IDXW    = (C_NUM_SLAVES > 1) ? $clog2(C_NUM_SLAVES) : 1;
  localparam int unsigned C_SHIFT = $clog2(C_SLAVE_SPAN);
  localparam logic [31:0] C_RANGE = 32'(C_NUM_SLAVES) * C_SLAVE_SPAN;
  localparam logic [7:0]  C_TO    = 8'(C_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [IDXW-1:0]         r_idx, w_idx_nxt;
  logic [7:0]              r_cnt, w_cnt_nxt;
  logic [C_NUM_SLAVES-1:0] r_sel, w_sel_nxt;
  logic [31:0]             r_dbus, w_dbus_nxt;
  logic                    r_xack, w_xack_nxt;
  logic                    r_eack, w_eack_nxt;
  logic                    r_tsup, w_tsup_nxt;

  logic [31:0]             w_addr, w_off, w_idx_full, w_cur_data;
  logic                    w_hit, w_cur_ack, w_cur_sup;
  logic [IDXW-1:0]         w_dec_idx;
  logic [C_NUM_SLAVES-1:0] w_dec_sel;
  logic                    w_unused;

  // The offset compare alone rejects addresses below the base, because those wrap to huge offsets.
  assign w_addr     = OPB_ABus;
  assign w_off      = w_addr - C_BASEADDR;
  assign w_hit      = (w_addr >= C_BASEADDR) && (w_off < C_RANGE);
  assign w_idx_full = w_off >> C_SHIFT;
  assign w_dec_idx  = w_idx_full[IDXW-1:0];
  assign w_cur_ack  = S_xferAck[r_idx];
  assign w_cur_sup  = S_toutSup[r_idx];
  assign w_cur_data = S_DBus[32*r_idx +: 32];
  assign w_unused   = &{1'b0, OPB_seqAddr, w_idx_full};

  always_comb begin
    for (int k = 0; k < int'(C_NUM_SLAVES); k++) begin
      w_dec_sel[k] = (w_dec_idx == IDXW'(k));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_dbus_nxt  = '0;
    w_xack_nxt  = 1'b0;
    w_eack_nxt  = 1'b0;
    w_tsup_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sel_nxt = '0;
        if (OPB_select && w_hit) begin
          w_idx_nxt   = w_dec_idx;
          w_cnt_nxt   = '0;
          w_sel_nxt   = w_dec_sel;
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!OPB_select) begin
          w_sel_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_cur_ack) begin
          w_xack_nxt  = 1'b1;
          w_dbus_nxt  = OPB_RNW ? w_cur_data : 32'h0;
          w_sel_nxt   = '0;
          w_state_nxt = ST_GAP;
        end else if (w_cur_sup) begin
          w_tsup_nxt  = 1'b1;
        end else if (r_cnt >= C_TO) begin
          // The counter has spent one full cycle at the limit with no ack.
          w_eack_nxt  = 1'b1;
          w_sel_nxt   = '0;
          w_state_nxt = ST_GAP;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      ST_GAP: begin
        w_sel_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_sel_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_dbus  <= '0;
      r_xack  <= 1'b0;
      r_eack  <= 1'b0;
      r_tsup  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_dbus  <= w_dbus_nxt;
      r_xack  <= w_xack_nxt;
      r_eack  <= w_eack_nxt;
      r_tsup  <= w_tsup_nxt;
    end
  end

  assign Sl_DBus     = r_dbus;
  assign Sl_xferAck  = r_xack;
  assign Sl_errAck   = r_eack;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = r_tsup;
  assign S_select    = r_sel;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_opb_slave_bank_ctrl.sv
// Bench for opb_slave_bank_ctrl. Each transfer is run against a transfer-level model.
// The model predicts the cycle of xferAck or errAck from the ack cycle and the count of unsuppressed cycles.
module tb_opb_slave_bank_ctrl;

  localparam int          NS      = 4;
  localparam logic [31:0] BASE    = 32'h01188000;
  localparam logic [31:0] SPAN    = 32'h00000100;
  localparam int          TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [0:31]     abus;
  logic            rnw, sel_in, seq_addr;
  logic [0:31]     sl_dbus;
  logic            sl_xack, sl_eack, sl_retry, sl_tsup;
  logic [NS-1:0]   s_select;
  logic [32*NS-1:0] s_dbus;
  logic [NS-1:0]   s_xack, s_tsup;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  opb_slave_bank_ctrl #(
    .C_NUM_SLAVES(NS), .C_BASEADDR(BASE), .C_SLAVE_SPAN(SPAN), .C_TIMEOUT(TIMEOUT)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_RNW(rnw),
    .OPB_select(sel_in), .OPB_seqAddr(seq_addr),
    .Sl_DBus(sl_dbus), .Sl_xferAck(sl_xack), .Sl_errAck(sl_eack),
    .Sl_retry(sl_retry), .Sl_toutSup(sl_tsup),
    .S_select(s_select), .S_DBus(s_dbus), .S_xferAck(s_xack), .S_toutSup(s_tsup),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic bit model_hit(input logic [31:0] a);
    longint unsigned la = a;
    return (la >= longint'(BASE)) && (la < longint'(BASE) + longint'(NS) * longint'(SPAN));
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / SPAN);
  endfunction

  function automatic bit in_sup(input int k, input int s0, input int sl);
    return (sl > 0) && (k >= s0) && (k < s0 + sl);
  endfunction

  // One transfer: cycle t_k is the k-th cycle after the edge that latches the select.
  // ack_at < 0 means the slave never acks. miss_len is the number of cycles to watch on a decode miss.
  task automatic run_xfer(input logic [31:0] addr, input bit rd, input int ack_at,
                          input int s0, input int sl, input logic [31:0] data,
                          input bit hold_sel, input int miss_len);
    bit hit = model_hit(addr);
    int idx = hit ? model_idx(addr) : 0;
    int unsup = 0, term = -1, end_c;
    bit is_ack = 1'b0;
    logic [NS-1:0] onehot = NS'(1) << idx;
    logic [NS-1:0] exp_sel;
    logic [31:0]   exp_db;
    bit exp_x, exp_e, exp_t;
    // The slave acks in cycle ack_at, or errAck follows the (TIMEOUT+1)-th unsuppressed cycle, whichever is first.
    for (int m = 0; m < 400 && term < 0; m++) begin
      if (m == ack_at) begin term = m; is_ack = 1'b1; end
      else if (!in_sup(m, s0, sl)) begin
        unsup++;
        if (unsup == TIMEOUT + 1) term = m;
      end
    end
    end_c = hit ? term + 1 : miss_len;
    @(negedge clk);
    n_checks++;
    if (s_select !== '0) begin
      n_fail++;
      $display("FAIL pre_select addr=%h got=%b exp=0", addr, s_select);
    end
    abus = addr; rnw = rd; sel_in = 1'b1;
    for (int j = 0; j < NS; j++) s_dbus[32*j +: 32] = $urandom;
    if (hit) s_dbus[32*idx +: 32] = data;
    s_xack = '0; s_tsup = '0;
    for (int k = 0; k <= end_c; k++) begin
      @(negedge clk);
      exp_sel = (hit && k < end_c) ? onehot : '0;
      exp_x   = hit && (k == end_c) && is_ack;
      exp_e   = hit && (k == end_c) && !is_ack;
      exp_db  = (exp_x && rd) ? data : 32'h0;
      exp_t   = hit && (k >= 1) && (k < end_c) && in_sup(k - 1, s0, sl);
      n_checks++;
      if (s_select !== exp_sel || sl_xack !== exp_x || sl_eack !== exp_e ||
          sl_dbus !== exp_db || sl_tsup !== exp_t || sl_retry !== 1'b0) begin
        n_fail++;
        $display("FAIL xfer addr=%h t%0d got sel=%b xack=%b eack=%b db=%h tsup=%b retry=%b exp sel=%b xack=%b eack=%b db=%h tsup=%b",
                 addr, k, s_select, sl_xack, sl_eack, sl_dbus, sl_tsup, sl_retry,
                 exp_sel, exp_x, exp_e, exp_db, exp_t);
      end
      if (k == end_c) begin
        if (!hold_sel) sel_in = 1'b0;
        s_xack = '0; s_tsup = '0;
      end else begin
        s_xack = NS'($urandom) & ~onehot;
        s_tsup = NS'($urandom) & ~onehot;
        if (hit && k == ack_at) s_xack[idx] = 1'b1;
        if (hit && in_sup(k, s0, sl)) s_tsup[idx] = 1'b1;
        if (!hit) s_xack = NS'($urandom);
      end
    end
    if (!hit) sel_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel_in = 1'b0; abus = '0; rnw = 1'b0; seq_addr = 1'b0;
    s_dbus = '0; s_xack = '0; s_tsup = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_select !== '0 || sl_dbus !== '0 || sl_xack !== 1'b0 || sl_eack !== 1'b0 ||
        sl_tsup !== 1'b0 || sl_retry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset got sel=%b db=%h xack=%b eack=%b tsup=%b exp all 0",
               s_select, sl_dbus, sl_xack, sl_eack, sl_tsup);
    end
  endtask

  task automatic test_read();
    run_xfer(32'h01188204, 1'b1, 3, 0, 0, 32'hDEADBEEF, 1'b0, 0);
  endtask

  task automatic test_write();
    run_xfer(32'h01188000, 1'b0, 1, 0, 0, 32'hCAFEF00D, 1'b0, 0);
  endtask

  task automatic test_miss();
    run_xfer(32'h01188400, 1'b1, -1, 0, 0, 32'h0, 1'b0, 40);
    run_xfer(32'h01187FFC, 1'b0, -1, 0, 0, 32'h0, 1'b0, 20);
    run_xfer(32'h011883FC, 1'b1, 0, 0, 0, 32'h12345678, 1'b0, 0);
  endtask

  task automatic test_timeout();
    run_xfer(32'h01188100, 1'b1, -1, 0, 0, 32'h0, 1'b0, 0);
    run_xfer(32'h01188100, 1'b1, -1, 3, 10, 32'h0, 1'b0, 0);
  endtask

  task automatic test_ack_at_expiry();
    run_xfer(32'h01188104, 1'b1, TIMEOUT, 0, 0, 32'hA5A5A5A5, 1'b0, 0);
    run_xfer(32'h01188308, 1'b1, TIMEOUT + 1, 0, 0, 32'h5A5A5A5A, 1'b0, 0);
  endtask

  task automatic test_abort(input bit use_rst);
    @(negedge clk);
    abus = 32'h01188200; rnw = 1'b1; sel_in = 1'b1; s_xack = '0; s_tsup = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (s_select !== ((k < 3) ? 4'b0100 : 4'b0000) || sl_xack !== 1'b0 || sl_eack !== 1'b0) begin
        n_fail++;
        $display("FAIL abort rst=%0b t%0d got sel=%b xack=%b eack=%b exp sel=%b no acks",
                 use_rst, k, s_select, sl_xack, sl_eack, (k < 3) ? 4'b0100 : 4'b0000);
      end
      rst = 1'b0;
      if (k == 2) begin
        if (use_rst) rst = 1'b1;
        else sel_in = 1'b0;
      end
      if (k == 3) begin
        sel_in = 1'b0;
        s_xack = 4'b0100;
      end else s_xack = '0;
    end
    run_xfer(32'h01188200, 1'b1, 2, 0, 0, 32'h0BADF00D, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_xfer(32'h01188300, 1'b1, 0, 0, 0, 32'h11111111, 1'b1, 0);
    run_xfer(32'h01188300, 1'b1, 1, 0, 0, 32'h22222222, 1'b1, 0);
    run_xfer(32'h01188300, 1'b0, 2, 0, 0, 32'h33333333, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int ack, s0, sl, r;
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE + 32'(NS) * SPAN + 32'($urandom_range(0, 255)) * 4;
      else if (r == 1) a = BASE - 32'($urandom_range(1, 64)) * 4;
      else             a = BASE + 32'($urandom_range(0, NS * 64 - 1)) * 4;
      ack = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 4));
      sl  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0;
      s0  = $urandom_range(0, 12);
      run_xfer(a, 1'($urandom), ack, s0, sl, $urandom, 1'b0, 12);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_miss();
    test_timeout();
    test_ack_at_expiry();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
